// File: rtl/bmult_sched_pkg.sv
// Shared types and helpers for the Bmult24x24 sharing scheduler.
package bmult_sched_pkg;

  // Index width for n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 24;
  localparam int ID_W     = clog2_min1(DEF_NREQ);

  typedef struct packed {
    logic [2*DEF_W-1:0] p;
    logic [ID_W-1:0]    id;
  } res_entry_t;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/bmult_share_sched_fifo.sv
// First-word-fall-through result FIFO; head entry is visible while not empty.
module bmult_res_fifo
  import bmult_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = res_entry_t,
  parameter int  CNT_W   = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = clog2_min1(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy; push and pop together keep the count.
  always_comb begin
    wr_d  = push ? bump(wr_q) : wr_q;
    rd_d  = pop  ? bump(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/bmult_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ clients.
// Operands are registered into the multiplier, the owner id rides a tag pipe
// matched to the multiplier latency, and tagged products land in a FIFO.
module bmult_share_sched
  import bmult_sched_pkg::*;
#(
  parameter int  NREQ       = 4,
  parameter int  W          = 24,
  parameter int  MULT_LAT   = 1,
  parameter int  FIFO_DEPTH = 4,
  localparam int IDW        = clog2_min1(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][W-1:0] req_a,
  input  logic [NREQ-1:0][W-1:0] req_b,
  output logic [W-1:0]           mult_a,
  output logic [W-1:0]           mult_b,
  input  logic [2*W-1:0]         mult_p,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*W-1:0]         res_p,
  output logic [IDW-1:0]         res_id,
  output logic                   busy
);

  localparam int CNT_W = clog2_min1(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  if (FIFO_DEPTH < 1 || NREQ < 2) begin : g_bad_cfg
    $error("bmult_share_sched: FIFO_DEPTH must be >= 1 and NREQ >= 2");
  end

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [IDW-1:0] id;
  } entry_t;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } ptag_t;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]     mult_a_q, mult_b_q;
  ptag_t            tag_q [MULT_LAT+1];
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OCC_W-1:0] occ;
  logic [IDW-1:0]   grant;
  logic             found;
  logic             issue_en;
  logic             accept;
  logic             push;
  logic             pop;
  logic             empty;
  int               idx;
  entry_t           fifo_din, fifo_dout;

  // Credit check: every in-flight product already owns a FIFO slot. The gate on
  // rst_n keeps the request side quiet the instant reset asserts.
  assign occ      = OCC_W'(inflight_q) + OCC_W'(fifo_cnt);
  assign issue_en = rst_n && (occ < OCC_W'(FIFO_DEPTH));

  // Round-robin search from ptr_q upward, wrapping; recomputed every cycle.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready = '0;
    if (found && issue_en) req_ready[grant] = 1'b1;
  end

  assign accept = found && issue_en;
  assign push   = tag_q[MULT_LAT].v;
  assign pop    = res_valid && res_ready;

  // Pointer advance and in-flight bookkeeping.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    inflight_d = inflight_q;
    case ({accept, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Issue registers and tag pipe; operands hold between accepts to avoid toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      inflight_q <= '0;
      for (int i = 0; i <= MULT_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      if (accept) begin
        mult_a_q <= req_a[grant];
        mult_b_q <= req_b[grant];
      end
      tag_q[0] <= '{v: accept, id: grant};
      for (int i = 1; i <= MULT_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign fifo_din = '{p: mult_p, id: tag_q[MULT_LAT].id};

  bmult_res_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign res_valid = !empty;
  assign res_p     = res_valid ? fifo_dout.p  : '0;
  assign res_id    = res_valid ? fifo_dout.id : '0;
  assign busy      = (occ != '0);

endmodule

// File: tb/tb_bmult_share_sched.sv
module tb_bmult_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 24;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [1:0]     id;
  } exp_t;

  typedef struct {
    int          id;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][W-1:0] req_a = '0;
  logic [NREQ-1:0][W-1:0] req_b = '0;
  logic [W-1:0]           mult_a, mult_b;
  logic [2*W-1:0]         mult_p, mult_reg = '0, noise = '0;
  logic                   res_valid;
  logic                   res_ready = 1'b1;
  logic [2*W-1:0]         res_p;
  logic [1:0]             res_id;
  logic                   busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   acc_log[$];
  logic hold_pend = 1'b0;
  logic [47:0] hold_p;
  logic [1:0]  hold_id;
  exp_t e_m;

  bmult_share_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .res_valid(res_valid), .res_ready(res_ready),
    .res_p(res_p), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // One-stage multiplier model; noise lets the bench wiggle mult_p on purpose.
  always @(posedge clk) mult_reg <= 48'(mult_a) * 48'(mult_b);
  assign mult_p = mult_reg ^ noise;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: record accepts, compare pops, watch hold and overflow.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_p", 64'(res_p), 64'(hold_p));
        chk("hold_id", 64'(res_id), 64'(hold_id));
      end
      if ($countones(req_ready) > 1) chk("ready_onehot", 64'(req_ready), 64'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{p: 48'(req_a[i]) * 48'(req_b[i]), id: 2'(i)});
          acc_log.push_back(i);
        end
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e_m = sb.pop_front();
          chk("res_p", 64'(res_p), 64'(e_m.p));
          chk("res_id", 64'(res_id), 64'(e_m.id));
        end
      end
      if (dut.push) chk("push_while_full", 64'(dut.fifo_cnt == 3'd4), 64'd0);
      hold_pend = res_valid && !res_ready;
      hold_p    = res_p;
      hold_id   = res_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    res_ready = 1'b1;
    noise     = '0;
    req_valid = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_p", 64'(res_p), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = '0;
    tick();
    tick();
    sb.delete();
    acc_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    res_ready = 1'b1;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[6];
    logic got;
    int n;
    bit seen0;

    vt[0] = '{1, 24'h000000, 24'hABCDEF, 48'h0};
    vt[1] = '{2, 24'h000001, 24'h800000, 48'h000000800000};
    vt[2] = '{3, 24'h800000, 24'h800000, 48'h400000000000};
    vt[3] = '{0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vt[4] = '{1, 24'h123456, 24'h000010, 48'h000001234560};
    vt[5] = '{2, 24'h000002, 24'h000003, 48'h000000000006};

    // 1: single max operands and latency
    apply_reset();
    req_valid = 4'b0100;
    req_a[2] = 24'hFFFFFF;
    req_b[2] = 24'hFFFFFF;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t1_res_valid", 64'(res_valid), (c == 3) ? 64'd1 : 64'd0);
      chk("t1_busy", 64'(busy), (c == 4) ? 64'd0 : 64'd1);
      if (c == 3) begin
        chk("t1_res_p", 64'(res_p), 64'hFFFFFE000001);
        chk("t1_res_id", 64'(res_id), 64'd2);
      end
      tick();
    end
    drain();

    // 2: full contention, one accept and one result per cycle
    apply_reset();
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 24'(i + 1);
      req_b[i] = 24'h10;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 3) chk("t2_res_stream", 64'(res_valid), 64'd1);
      tick();
    end
    req_valid = '0;
    chk("t2_accepts", 64'(acc_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++)
      chk("t2_order", 64'(acc_log[k]), 64'(k % NREQ));
    drain();

    // 3: backpressure then resume
    apply_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_a[0] = 24'd1;
    req_b[0] = 24'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = req_ready[0];
      tick();
      if (got) req_a[0] = req_a[0] + 1'b1;
    end
    chk("t3_accepts_stalled", 64'(acc_log.size()), 64'd4);
    @(negedge clk);
    chk("t3_ready_blocked", 64'(req_ready), 64'd0);
    chk("t3_head_valid", 64'(res_valid), 64'd1);
    chk("t3_head_p", 64'(res_p), 64'd3);
    tick();
    res_ready = 1'b1;
    n = 0;
    while (acc_log.size() < 12 && n < 40) begin
      @(negedge clk);
      got = req_ready[0];
      tick();
      if (got) req_a[0] = req_a[0] + 1'b1;
      n++;
    end
    req_valid = '0;
    chk("t3_accepts_total", 64'(acc_log.size()), 64'd12);
    drain();

    // 4: sparse fairness
    apply_reset();
    req_valid = 4'b1010;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 24'(i + 5);
      req_b[i] = 24'(i + 9);
    end
    repeat (4) tick();
    chk("t4_accepts", 64'(acc_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++)
      chk("t4_order", 64'(acc_log[k]), (k % 2 == 0) ? 64'd1 : 64'd3);
    req_valid = 4'b1011;
    seen0 = 1'b0;
    n = 0;
    while (!seen0 && n < NREQ) begin
      @(negedge clk);
      if (req_ready[0]) seen0 = 1'b1;
      tick();
      n++;
    end
    req_valid = '0;
    chk("t4_req0_granted", 64'(seen0), 64'd1);
    drain();

    // 5: reset with two in flight and two buffered
    apply_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_a[0] = 24'd2;
    req_b[0] = 24'd9;
    repeat (4) tick();
    chk("t5_pre_fifo", 64'(dut.fifo_cnt), 64'd2);
    chk("t5_pre_busy", 64'(busy), 64'd1);
    req_valid = 4'hF;
    res_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_res_valid", 64'(res_valid), 64'd0);
    chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    acc_log.delete();
    req_valid = '0;
    tick();
    tick();
    sb.delete();
    acc_log.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      noise = {$urandom, $urandom};
      @(negedge clk);
      chk("t5_quiet_res_valid", 64'(res_valid), 64'd0);
      tick();
    end
    noise = '0;
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 24'(i + 2);
      req_b[i] = 24'h3;
    end
    @(negedge clk);
    chk("t5_first_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    drain();

    // 6: edge operand table
    apply_reset();
    foreach (vt[v]) begin
      req_a[vt[v].id] = vt[v].a;
      req_b[vt[v].id] = vt[v].b;
      req_valid = 4'(1 << vt[v].id);
      got = 1'b0;
      n = 0;
      while (!got && n < 10) begin
        @(negedge clk);
        got = req_ready[vt[v].id];
        tick();
        n++;
      end
      req_valid = '0;
      chk("t6_accept", 64'(got), 64'd1);
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 10) begin
        tick();
        @(negedge clk);
        n++;
      end
      chk("t6_res_valid", 64'(res_valid), 64'd1);
      chk("t6_res_p", 64'(res_p), 64'(vt[v].p));
      chk("t6_res_id", 64'(res_id), 64'(vt[v].id));
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
